// File: rtl/spi_lane_shift.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_lane_shift : 1/2/4-lane SPI character shift engine with separate RX reg
// Revision 1.0
// ----------------------------------------------------------------------------
module spi_lane_shift #(
  parameter int MAX_CHAR = 128,
  parameter int LEN_BITS = 7
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  latch,
  input  logic [MAX_CHAR/8-1:0] byte_sel,
  input  logic [MAX_CHAR-1:0]   p_in,
  input  logic [LEN_BITS-1:0]   len,
  input  logic [1:0]            mode,
  input  logic                  lsb,
  input  logic                  go,
  input  logic                  pos_edge,
  input  logic                  neg_edge,
  input  logic                  tx_negedge,
  input  logic                  rx_negedge,
  input  logic                  tx_en,
  input  logic                  rx_en,
  input  logic [3:0]            sd_in,
  output logic [3:0]            sd_out,
  output logic [3:0]            sd_oe,
  output logic [MAX_CHAR-1:0]   p_out,
  output logic                  tip,
  output logic                  last,
  output logic                  done
);

  localparam int CW = LEN_BITS + 1;
  localparam int IW = LEN_BITS + 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state, w_state_next;
  logic [MAX_CHAR-1:0] r_tx, w_tx_next;
  logic [MAX_CHAR-1:0] r_rx, w_rx_next;
  logic [LEN_BITS-1:0] r_len, w_len_next;
  logic [1:0]          r_mode, w_mode_next;
  logic                r_lsb, w_lsb_next;
  logic [CW-1:0]       r_tx_idx, w_tx_idx_next;
  logic [CW-1:0]       r_rx_idx, w_rx_idx_next;
  logic [3:0]          r_sd_out, w_sd_out_next;
  logic [3:0]          r_sd_oe, w_sd_oe_next;
  logic                r_done, w_done_next;

  logic [LEN_BITS-1:0] w_len_sel;
  logic [1:0]          w_mode_sel;
  logic                w_lsb_sel;
  logic [CW-1:0]       w_nbits, w_beats, w_tx_k;
  logic [2:0]          w_lanes;
  logic [3:0]          w_mask, w_lane_in, w_tx_beat;
  logic                w_busy, w_tx_evt, w_rx_evt;

  // Character bit carried by a lane on beat k; negative or >= n means padding.
  function automatic logic signed [IW-1:0] bit_index(
    input logic [CW-1:0] n,
    input logic [2:0]    l,
    input logic          lsb_first,
    input logic [CW-1:0] k,
    input logic [2:0]    lane
  );
    logic signed [IW-1:0] ns, ls, ks, lane_s;
    ns     = $signed(IW'(n));
    ls     = $signed(IW'(l));
    ks     = $signed(IW'(k));
    lane_s = $signed(IW'(lane));
    if (lsb_first) bit_index = ks * ls + lane_s;
    else           bit_index = ns - ks * ls - ls + lane_s;
  endfunction

  function automatic logic lane_ok(
    input logic signed [IW-1:0] idx,
    input logic [CW-1:0]        n,
    input logic [2:0]           l,
    input logic [2:0]           lane
  );
    lane_ok = (lane < l) && !idx[IW-1] && (idx < $signed(IW'(n)));
  endfunction

  function automatic logic [3:0] beat_out(
    input logic [MAX_CHAR-1:0] data,
    input logic [CW-1:0]       n,
    input logic [2:0]          l,
    input logic                lsb_first,
    input logic [CW-1:0]       k
  );
    logic signed [IW-1:0] idx;
    beat_out = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      idx = bit_index(n, l, lsb_first, k, 3'(i));
      if (lane_ok(idx, n, l, 3'(i))) beat_out[i] = data[idx[LEN_BITS-1:0]];
    end
  endfunction

  function automatic logic [MAX_CHAR-1:0] rx_merge(
    input logic [MAX_CHAR-1:0] cur,
    input logic [3:0]          lanes_in,
    input logic [CW-1:0]       n,
    input logic [2:0]          l,
    input logic                lsb_first,
    input logic [CW-1:0]       k
  );
    logic signed [IW-1:0] idx;
    rx_merge = cur;
    for (int i = 0; i < 4; i++) begin
      idx = bit_index(n, l, lsb_first, k, 3'(i));
      if (lane_ok(idx, n, l, 3'(i))) rx_merge[idx[LEN_BITS-1:0]] = lanes_in[i];
    end
  endfunction

  // Geometry tracks live inputs while idle so sd_out previews beat 0.
  assign w_busy     = (r_state == ST_BUSY);
  assign w_len_sel  = w_busy ? r_len  : len;
  assign w_mode_sel = w_busy ? r_mode : mode;
  assign w_lsb_sel  = w_busy ? r_lsb  : lsb;

  always_comb begin
    w_lanes = 3'd1;
    w_mask  = 4'b0001;
    case (w_mode_sel)
      2'b01:   begin w_lanes = 3'd2; w_mask = 4'b0011; end
      2'b10:   begin w_lanes = 3'd4; w_mask = 4'b1111; end
      default: begin w_lanes = 3'd1; w_mask = 4'b0001; end
    endcase
  end

  assign w_nbits = (w_len_sel == '0) ? CW'(MAX_CHAR) : CW'(w_len_sel) + CW'(1);

  always_comb begin
    w_beats = w_nbits;
    case (w_lanes)
      3'd2:    w_beats = (w_nbits + CW'(1)) >> 1;
      3'd4:    w_beats = (w_nbits + CW'(3)) >> 2;
      default: w_beats = w_nbits;
    endcase
  end

  assign w_tx_evt  = w_busy && (tx_negedge ? neg_edge : pos_edge);
  assign w_rx_evt  = w_busy && (rx_negedge ? neg_edge : pos_edge);
  assign w_lane_in = (w_lanes == 3'd1) ? {3'b000, sd_in[1]} : sd_in;
  assign w_tx_k    = w_busy ? r_tx_idx + CW'(1) : '0;
  assign w_tx_beat = beat_out(r_tx, w_nbits, w_lanes, w_lsb_sel, w_tx_k);

  always_comb begin
    w_state_next  = r_state;
    w_tx_next     = r_tx;
    w_rx_next     = r_rx;
    w_len_next    = r_len;
    w_mode_next   = r_mode;
    w_lsb_next    = r_lsb;
    w_tx_idx_next = r_tx_idx;
    w_rx_idx_next = r_rx_idx;
    w_sd_out_next = r_sd_out;
    w_done_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sd_out_next = w_tx_beat;
        if (latch) begin
          for (int b = 0; b < MAX_CHAR / 8; b++) begin
            if (byte_sel[b]) w_tx_next[b*8 +: 8] = p_in[b*8 +: 8];
          end
        end
        if (go) begin
          w_len_next    = len;
          w_mode_next   = mode;
          w_lsb_next    = lsb;
          w_rx_next     = '0;
          w_tx_idx_next = '0;
          w_rx_idx_next = '0;
          w_state_next  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_tx_evt && (r_tx_idx < w_beats - CW'(1))) begin
          w_tx_idx_next = r_tx_idx + CW'(1);
          w_sd_out_next = w_tx_beat;
        end
        if (w_rx_evt) begin
          if (rx_en) begin
            w_rx_next = rx_merge(r_rx, w_lane_in, w_nbits, w_lanes, w_lsb_sel, r_rx_idx);
          end
          w_rx_idx_next = r_rx_idx + CW'(1);
          if (r_rx_idx == w_beats - CW'(1)) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_sd_oe_next = ((w_state_next == ST_BUSY) && tx_en) ? w_mask : 4'b0000;
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tx     <= '0;
      r_rx     <= '0;
      r_len    <= '0;
      r_mode   <= '0;
      r_lsb    <= 1'b0;
      r_tx_idx <= '0;
      r_rx_idx <= '0;
      r_sd_out <= '0;
      r_sd_oe  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_tx     <= w_tx_next;
      r_rx     <= w_rx_next;
      r_len    <= w_len_next;
      r_mode   <= w_mode_next;
      r_lsb    <= w_lsb_next;
      r_tx_idx <= w_tx_idx_next;
      r_rx_idx <= w_rx_idx_next;
      r_sd_out <= w_sd_out_next;
      r_sd_oe  <= w_sd_oe_next;
      r_done   <= w_done_next;
    end
  end

  assign sd_out = r_sd_out;
  assign sd_oe  = r_sd_oe;
  assign p_out  = r_rx;
  assign tip    = w_busy;
  assign done   = r_done;
  assign last   = w_busy && (r_rx_idx == w_beats - CW'(1));

endmodule
`default_nettype wire

// File: tb/tb_spi_lane_shift.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_lane_shift : randomized bench against a bit-stream model of the shifter
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_spi_lane_shift;

  localparam int MAX_CHAR = 128;
  localparam int LEN_BITS = 7;

  logic                  clk_i = 1'b0;
  logic                  rst;
  logic                  latch, go, lsb, pos_edge, neg_edge;
  logic                  tx_negedge, rx_negedge, tx_en, rx_en;
  logic [MAX_CHAR/8-1:0] byte_sel;
  logic [MAX_CHAR-1:0]   p_in;
  logic [LEN_BITS-1:0]   len;
  logic [1:0]            mode;
  logic [3:0]            sd_in;
  logic [3:0]            sd_out, sd_oe;
  logic [MAX_CHAR-1:0]   p_out;
  logic                  tip, last, done;

  always #5 clk_i = ~clk_i;

  spi_lane_shift #(.MAX_CHAR(MAX_CHAR), .LEN_BITS(LEN_BITS)) dut (
    .clk_i(clk_i), .rst(rst), .latch(latch), .byte_sel(byte_sel), .p_in(p_in),
    .len(len), .mode(mode), .lsb(lsb), .go(go), .pos_edge(pos_edge),
    .neg_edge(neg_edge), .tx_negedge(tx_negedge), .rx_negedge(rx_negedge),
    .tx_en(tx_en), .rx_en(rx_en), .sd_in(sd_in), .sd_out(sd_out), .sd_oe(sd_oe),
    .p_out(p_out), .tip(tip), .last(last), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [MAX_CHAR-1:0] got,
                     input logic [MAX_CHAR-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a character is a stream of bits (ascending for LSB-first,
  // descending for MSB-first) dealt L at a time; MSB-first fills the top lane first.
  logic [MAX_CHAR-1:0] m_txreg, m_rx;
  bit  m_tip, m_lsb, c_loop;
  int  m_n, m_l, m_b, m_tx, m_rx_i;

  function automatic int lanes_of(input logic [1:0] md);
    return (md == 2'b01) ? 2 : (md == 2'b10) ? 4 : 1;
  endfunction

  function automatic int nbits_of(input int ln);
    return (ln == 0) ? MAX_CHAR : ln + 1;
  endfunction

  function automatic logic [3:0] mask_of(input int l);
    return (l == 1) ? 4'b0001 : (l == 2) ? 4'b0011 : 4'b1111;
  endfunction

  function automatic int lane_bit(input int n, input int l, input bit lsbf,
                                  input int k, input int i);
    int p;
    p = lsbf ? k * l + i : k * l + (l - 1 - i);
    if (p >= n) return -1;
    return lsbf ? p : n - 1 - p;
  endfunction

  function automatic logic [3:0] beat_of(input logic [MAX_CHAR-1:0] d, input int n,
                                         input int l, input bit lsbf, input int k);
    logic [3:0] r;
    int b;
    r = 4'b0000;
    for (int i = 0; i < l; i++) begin
      b = lane_bit(n, l, lsbf, k, i);
      if (b >= 0) r[i] = d[b];
    end
    return r;
  endfunction

  // One clk_i cycle: inputs applied at negedge, model advanced and DUT checked at posedge+1.
  task automatic step(input bit pe, input bit ne);
    logic [3:0] lane_v, lane_in, rnd;
    bit tx_ev, rx_ev, done_e;
    int b;
    rnd      = 4'($urandom);
    lane_v   = c_loop ? beat_of(m_txreg, m_n, m_l, m_lsb, m_tx) : 4'($urandom);
    pos_edge = pe;
    neg_edge = ne;
    sd_in    = (m_l == 1) ? {rnd[3:2], lane_v[0], rnd[0]} : lane_v;
    lane_in  = (m_l == 1) ? {3'b000, sd_in[1]} : sd_in;
    tx_ev    = m_tip && (tx_negedge ? ne : pe);
    rx_ev    = m_tip && (rx_negedge ? ne : pe);
    done_e   = 1'b0;
    @(posedge clk_i);
    #1;
    if (!m_tip) begin
      if (latch) begin
        for (int j = 0; j < MAX_CHAR / 8; j++)
          if (byte_sel[j]) m_txreg[j*8 +: 8] = p_in[j*8 +: 8];
      end
      if (go) begin
        m_n    = nbits_of(int'(len));
        m_l    = lanes_of(mode);
        m_lsb  = lsb;
        m_b    = (m_n + m_l - 1) / m_l;
        m_tx   = 0;
        m_rx_i = 0;
        m_rx   = '0;
        m_tip  = 1'b1;
      end
    end else begin
      if (tx_ev && m_tx < m_b - 1) m_tx++;
      if (rx_ev) begin
        if (rx_en) begin
          for (int i = 0; i < m_l; i++) begin
            b = lane_bit(m_n, m_l, m_lsb, m_rx_i, i);
            if (b >= 0) m_rx[b] = lane_in[i];
          end
        end
        m_rx_i++;
        if (m_rx_i == m_b) begin
          m_tip  = 1'b0;
          done_e = 1'b1;
        end
      end
    end
    chk("tip", tip, m_tip);
    chk("done", done, done_e);
    chk("last", last, m_tip && (m_rx_i == m_b - 1));
    chk("sd_oe", sd_oe, (m_tip && tx_en) ? mask_of(m_l) : 4'b0000);
    chk("p_out", p_out, m_rx);
    if (m_tip || done_e) chk("sd_out", sd_out, beat_of(m_txreg, m_n, m_l, m_lsb, m_tx));
    @(negedge clk_i);
    pos_edge = 1'b0;
    neg_edge = 1'b0;
    go       = 1'b0;
    latch    = 1'b0;
  endtask

  task automatic run_xfer(input int ln, input logic [1:0] md, input bit lsbf,
                          input logic [MAX_CHAR-1:0] data, input bit txn, input bit rxn,
                          input bit ten, input bit ren, input bit lp, input bit poke,
                          input bit partial, input int abort_after);
    int  gap, cyc, strobes;
    bit  phase, poked;
    logic [MAX_CHAR-1:0] nmask;
    len = LEN_BITS'(ln); mode = md; lsb = lsbf;
    tx_negedge = txn; rx_negedge = rxn; tx_en = ten; rx_en = ren; c_loop = lp;
    p_in     = data;
    byte_sel = partial ? (MAX_CHAR/8)'({$urandom, $urandom}) : '1;
    latch    = 1'b1;
    step(0, 0);
    step(0, 0);
    chk("idle_sd_out", sd_out, beat_of(m_txreg, nbits_of(ln), lanes_of(md), lsbf, 0));
    go = 1'b1;
    step(0, 0);
    phase = 1'b0; poked = 1'b0; cyc = 0; strobes = 0;
    while (m_tip && cyc < 3000) begin
      if (abort_after > 0 && strobes == abort_after) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_tip", tip, 0);
        chk("rst_last", last, 0);
        chk("rst_done", done, 0);
        chk("rst_sd_out", sd_out, 0);
        chk("rst_sd_oe", sd_oe, 0);
        chk("rst_p_out", p_out, 0);
        m_tip = 1'b0; m_txreg = '0; m_rx = '0; m_tx = 0; m_rx_i = 0;
        @(negedge clk_i);
        rst = 1'b0;
        repeat (3) step(1, 1);
        chk("rst_idle_sd_out", sd_out, beat_of(m_txreg, nbits_of(ln), lanes_of(md), lsbf, 0));
        return;
      end
      gap = $urandom_range(0, 2);
      repeat (gap) step(0, 0);
      cyc += gap;
      if (poke && !poked && m_rx_i >= m_b / 2) begin
        go = 1'b1; latch = 1'b1; p_in = ~data; byte_sel = '1;
        len = LEN_BITS'($urandom); mode = 2'($urandom); lsb = ~lsbf;
        step(0, 0);
        len = LEN_BITS'(ln); mode = md; lsb = lsbf; p_in = data;
        poked = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) step(1, 1);
      else begin
        if (phase) step(0, 1);
        else       step(1, 0);
        phase = ~phase;
      end
      strobes++;
      cyc++;
    end
    chk("xfer_timeout", m_tip, 0);
    if (lp && txn == rxn && ren) begin
      nmask = (nbits_of(ln) == MAX_CHAR) ? '1 : ((MAX_CHAR'(1) << nbits_of(ln)) - 1);
      chk("loop_p_out", p_out, m_txreg & nmask);
    end
    step(0, 0);
    step(0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; latch = 0; go = 0; lsb = 0; pos_edge = 0; neg_edge = 0;
    tx_negedge = 0; rx_negedge = 0; tx_en = 1; rx_en = 1; byte_sel = '0;
    p_in = '0; len = '0; mode = '0; sd_in = '0;
    m_txreg = '0; m_rx = '0; m_tip = 0; m_lsb = 0; c_loop = 0;
    m_n = 1; m_l = 1; m_b = 1; m_tx = 0; m_rx_i = 0;
    repeat (2) @(negedge clk_i);
    chk("reset_tip", tip, 0);
    chk("reset_last", last, 0);
    chk("reset_done", done, 0);
    chk("reset_sd_out", sd_out, 0);
    chk("reset_sd_oe", sd_oe, 0);
    chk("reset_p_out", p_out, 0);
    rst = 1'b0;
    step(0, 0);

    run_xfer(7,  2'b00, 0, 128'hA5,   0, 0, 1, 1, 1, 0, 0, 0);
    run_xfer(15, 2'b10, 1, 128'h1234, 0, 0, 1, 1, 1, 0, 0, 0);
    run_xfer(6,  2'b01, 0, 128'h55,   0, 0, 1, 1, 1, 0, 0, 0);
    run_xfer(0,  2'b00, 0, {$urandom, $urandom, $urandom, $urandom}, 1, 1, 1, 1, 1, 1, 0, 0);
    run_xfer(31, 2'b10, 0, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 1, 1, 0, 0, 0, 5);

    for (int t = 0; t < 14; t++) begin
      int ln;
      ln = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, MAX_CHAR - 1);
      run_xfer(ln, 2'($urandom), 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
               1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
               1'($urandom), (t % 3 == 0), 1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
